// File: rtl/dmux_sched_pkg.sv
// Shared types and helpers for the round-robin demux scheduler.
//   state_t       : EMPTY (no word held) / HOLD (one word held)
//   next_enabled  : round-robin successor of a destination under an enable mask
package dmux_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Widest destination count the helper handles.
  localparam int MAX_N = 8;

  // First k in sel+1, sel+2, ... (mod n) whose mask bit is set.
  // Scanning from the far end means the nearest enabled destination is the
  // last one written. The loop always reaches k == sel at distance n. So when
  // sel is the only enabled destination, the result is sel. With an empty
  // mask, the result is also sel.
  function automatic int next_enabled(input int sel, input logic [MAX_N-1:0] mask,
                                      input int n);
    int k;
    int result;
    result = sel;
    for (int i = MAX_N; i >= 1; i--) begin
      if (i <= n) begin
        k = (sel + i) % n;
        if (mask[k]) result = k;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/dmux_n.sv
// Combinational 1-to-N demultiplexer.
//   i_data  : word to steer
//   i_sel   : destination lane index
//   o_lanes : N_OUT lanes packed lane 0 at the LSBs; unselected lanes are 0
module dmux_n #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [WIDTH-1:0]       i_data,
  input  logic [SEL_W-1:0]       i_sel,
  output logic [N_OUT*WIDTH-1:0] o_lanes
);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_lane
      assign o_lanes[gi*WIDTH +: WIDTH] = (i_sel == SEL_W'(gi)) ? i_data : '0;
    end
  endgenerate

endmodule

// File: rtl/dmux_scheduler.sv
// Round-robin dispatcher in front of an N-way demux. It takes one word per
// valid/ready handshake and holds it. The word is then steered to the
// destination chosen by sel. Destinations that are disabled or stalled are
// skipped.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_data/valid/ready   : producer handshake
//   en_mask               : per-destination enable
//   out_ready             : per-destination ready
//   out_valid             : one-hot valid at sel
//   out_data              : packed lanes; only lane sel carries the held word
//   sel                   : registered destination select
//   skip                  : one-cycle pulse when a held word is reassigned
module dmux_scheduler
  import dmux_sched_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_OUT   = 4,
  parameter int SEL_W   = $clog2(N_OUT),
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OUT-1:0]       en_mask,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]       sel,
  output logic                   skip
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            r_state;
  logic [WIDTH-1:0]  r_hold;
  logic [SEL_W-1:0]  r_sel;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_skip;

  logic              w_full;
  logic              w_any_en;
  logic              w_sel_en;
  logic              w_fire;
  logic              w_accept;
  logic              w_timeout;
  logic [MAX_N-1:0]  w_mask8;
  logic [SEL_W-1:0]  w_nxt;
  logic [WIDTH-1:0]  w_lane_src;

  assign w_full   = (r_state == HOLD);
  assign w_any_en = |en_mask;
  assign w_sel_en = en_mask[r_sel];
  assign w_fire   = w_full & w_sel_en & out_ready[r_sel];
  // The slot frees up in the same cycle it drains, so words can arrive back to back.
  assign in_ready = w_any_en & (~w_full | w_fire);
  assign w_accept = in_valid & in_ready;
  assign w_timeout = (TIMEOUT > 0) && (r_stall_cnt == CNT_LAST);

  assign w_mask8 = MAX_N'(en_mask);
  assign w_nxt   = SEL_W'(next_enabled(int'(r_sel), w_mask8, N_OUT));

  // An all-zero mask freezes everything. The held word, sel and the counter
  // stay put until some destination is enabled again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_hold      <= '0;
      r_sel       <= '0;
      r_stall_cnt <= '0;
      r_skip      <= 1'b0;
    end else begin
      r_skip <= 1'b0;
      if (w_any_en) begin
        if (w_fire) begin
          r_sel       <= w_nxt;
          r_stall_cnt <= '0;
          r_state     <= w_accept ? HOLD : EMPTY;
          if (w_accept) r_hold <= in_data;
        end else if (w_full) begin
          // A disabled target or an expired stall moves the word on.
          // The word itself is never dropped.
          if (!w_sel_en || w_timeout) begin
            r_sel       <= w_nxt;
            r_stall_cnt <= '0;
            r_skip      <= 1'b1;
          end else if (r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end else begin
          // While empty, sel is not left parked on a disabled destination.
          if (!w_sel_en) r_sel <= w_nxt;
          if (w_accept) begin
            r_hold  <= in_data;
            r_state <= HOLD;
          end
        end
      end
    end
  end

  assign sel  = r_sel;
  assign skip = r_skip;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_valid
      assign out_valid[gi] = w_full & en_mask[gi] & (r_sel == SEL_W'(gi));
    end
  endgenerate

  assign w_lane_src = w_full ? r_hold : '0;

  dmux_n #(
    .WIDTH (WIDTH),
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_dmux (
    .i_data  (w_lane_src),
    .i_sel   (r_sel),
    .o_lanes (out_data)
  );

endmodule

// File: tb/tb_dmux_scheduler.sv
module tb_dmux_scheduler;

  localparam int WIDTH   = 16;
  localparam int N_OUT   = 4;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 8;

  logic                   clk;
  logic                   rst_n;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT-1:0]       en_mask;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [SEL_W-1:0]       sel;
  logic                   skip;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: one buffered word, a round-robin pointer and a stall count.
  bit m_full;
  int m_word;
  int m_sel;
  int m_cnt;
  bit m_skip;

  dmux_scheduler #(
    .WIDTH   (WIDTH),
    .N_OUT   (N_OUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .skip      (skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nxt(input int s, input logic [N_OUT-1:0] m);
    int r;
    bit found;
    r = s;
    found = 1'b0;
    for (int i = 1; i <= N_OUT; i++) begin
      if (!found && m[(s + i) % N_OUT]) begin
        r = (s + i) % N_OUT;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic exp_in_ready();
    bit fire;
    fire = m_full && en_mask[m_sel] && out_ready[m_sel];
    return (en_mask != 0) && (!m_full || fire);
  endfunction

  function automatic logic [N_OUT-1:0] exp_valid();
    logic [N_OUT-1:0] v;
    v = '0;
    if (m_full && en_mask[m_sel]) v[m_sel] = 1'b1;
    return v;
  endfunction

  function automatic logic [N_OUT*WIDTH-1:0] exp_data();
    logic [N_OUT*WIDTH-1:0] d;
    d = '0;
    if (m_full) d[m_sel*WIDTH +: WIDTH] = WIDTH'(m_word);
    return d;
  endfunction

  task automatic model_reset();
    m_full = 0; m_word = 0; m_sel = 0; m_cnt = 0; m_skip = 0;
  endtask

  // Work out the state after the coming rising edge from the present inputs.
  task automatic model_next();
    bit fire, acc;
    m_skip = 0;
    if (en_mask != 0) begin
      fire = m_full && en_mask[m_sel] && out_ready[m_sel];
      acc  = in_valid && exp_in_ready();
      if (fire) begin
        m_sel = nxt(m_sel, en_mask);
        m_cnt = 0;
        m_full = acc;
        if (acc) m_word = int'(in_data);
      end else if (m_full) begin
        if (!en_mask[m_sel] || (TIMEOUT > 0 && m_cnt == TIMEOUT - 1)) begin
          m_sel = nxt(m_sel, en_mask);
          m_cnt = 0;
          m_skip = 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (!en_mask[m_sel]) m_sel = nxt(m_sel, en_mask);
        if (acc) begin
          m_full = 1;
          m_word = int'(in_data);
        end
      end
    end
  endtask

  // Advance the model, then return at the next falling edge so new inputs can be driven.
  task automatic step();
    model_next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_data = '0; en_mask = 4'hF; out_ready = 4'hF;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (sel !== 2'd0) $display("FAIL reset_sel got=%0d exp=0", sel); else n_pass++;
    n_checks++;
    if (out_valid !== 4'h0) $display("FAIL reset_valid got=%b exp=0000", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_data got=%h exp=0", out_data); else n_pass++;
    n_checks++;
    if (skip !== 1'b0) $display("FAIL reset_skip got=%b exp=0", skip); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    $display("reset: sel=%0d out_valid=%b in_ready=%b", sel, out_valid, in_ready);
  endtask

  task automatic test_back_to_back();
    en_mask = 4'hF; out_ready = 4'hF;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c < 4);
      in_data  = WIDTH'(c + 1);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (sel !== SEL_W'(c - 1)) $display("FAIL b2b_sel c=%0d got=%0d exp=%0d", c, sel, c - 1);
        else n_pass++;
        n_checks++;
        if (out_data[(c-1)*WIDTH +: WIDTH] !== WIDTH'(c))
          $display("FAIL b2b_lane c=%0d got=%h exp=%h", c, out_data[(c-1)*WIDTH +: WIDTH], c);
        else n_pass++;
        n_checks++;
        if (out_valid !== 4'(1 << (c - 1)))
          $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, 4'(1 << (c - 1)));
        else n_pass++;
      end
      $display("b2b: cycle %0d sel=%0d out_valid=%b out_data=%h", c, sel, out_valid, out_data);
      step();
    end
    in_valid = 0;
  endtask

  task automatic test_mask_alternate();
    en_mask = 4'b1010; out_ready = 4'hF;
    for (int c = 0; c <= 4; c++) begin
      in_valid = (c < 4);
      in_data  = WIDTH'(16'h0100 + c);
      #1;
      if (c > 0) begin
        n_checks++;
        if (sel !== (((c - 1) % 2 == 0) ? 2'd1 : 2'd3))
          $display("FAIL alt_sel c=%0d got=%0d exp=%0d", c, sel, ((c - 1) % 2 == 0) ? 1 : 3);
        else n_pass++;
        n_checks++;
        if (out_data[0 +: WIDTH] !== '0 || out_data[2*WIDTH +: WIDTH] !== '0)
          $display("FAIL alt_lanes02 c=%0d got=%h exp=0", c, out_data);
        else n_pass++;
        n_checks++;
        if (out_data !== exp_data()) $display("FAIL alt_data c=%0d got=%h exp=%h", c, out_data, exp_data());
        else n_pass++;
      end
      $display("alt: cycle %0d sel=%0d out_valid=%b", c, sel, out_valid);
      step();
    end
    in_valid = 0;
  endtask

  task automatic test_timeout();
    // Park sel at 2 by enabling only destination 2 while empty.
    en_mask = 4'b0100; out_ready = 4'hF; in_valid = 0;
    step();
    en_mask = 4'hF; out_ready = 4'b1011; in_valid = 1; in_data = 16'h00AA;
    #1;
    n_checks++;
    if (sel !== 2'd2) $display("FAIL tmo_park_sel got=%0d exp=2", sel); else n_pass++;
    step();
    in_valid = 0;
    for (int h = 0; h < 8; h++) begin
      #1;
      n_checks++;
      if (sel !== 2'd2 || skip !== 1'b0 || out_valid !== 4'b0100)
        $display("FAIL tmo_hold h=%0d got sel=%0d skip=%b valid=%b exp sel=2 skip=0 valid=0100",
                 h, sel, skip, out_valid);
      else n_pass++;
      step();
    end
    #1;
    n_checks++;
    if (skip !== 1'b1 || sel !== 2'd3) $display("FAIL tmo_skip got skip=%b sel=%0d exp skip=1 sel=3", skip, sel);
    else n_pass++;
    n_checks++;
    if (out_data[3*WIDTH +: WIDTH] !== 16'h00AA || out_valid !== 4'b1000)
      $display("FAIL tmo_lane3 got=%h valid=%b exp=00aa valid=1000", out_data[3*WIDTH +: WIDTH], out_valid);
    else n_pass++;
    $display("timeout: skip=%b sel=%0d lane3=%h", skip, sel, out_data[3*WIDTH +: WIDTH]);
    step();
    #1;
    n_checks++;
    if (out_valid !== 4'h0 || skip !== 1'b0) $display("FAIL tmo_drain got valid=%b skip=%b exp 0000/0", out_valid, skip);
    else n_pass++;
  endtask

  task automatic test_drop_enable();
    en_mask = 4'b0010; out_ready = 4'h0; in_valid = 0;
    step();
    en_mask = 4'hF; in_valid = 1; in_data = 16'h1234;
    step();
    in_valid = 0;
    #1;
    n_checks++;
    if (sel !== 2'd1 || out_valid !== 4'b0010) $display("FAIL drop_hold got sel=%0d valid=%b exp 1/0010", sel, out_valid);
    else n_pass++;
    en_mask = 4'b1101;
    #1;
    n_checks++;
    if (out_valid !== 4'h0) $display("FAIL drop_valid got=%b exp=0000", out_valid); else n_pass++;
    step();
    #1;
    n_checks++;
    if (sel !== 2'd2 || skip !== 1'b1 || out_data[2*WIDTH +: WIDTH] !== 16'h1234)
      $display("FAIL drop_move got sel=%0d skip=%b lane2=%h exp 2/1/1234", sel, skip, out_data[2*WIDTH +: WIDTH]);
    else n_pass++;
    $display("drop: sel=%0d skip=%b lane2=%h", sel, skip, out_data[2*WIDTH +: WIDTH]);
    out_ready = 4'hF;
    step();
  endtask

  task automatic test_mask_zero();
    int deliveries;
    en_mask = 4'hF; out_ready = 4'h0; in_valid = 1; in_data = 16'h5555;
    step();
    in_valid = 0;
    step();
    en_mask = 4'h0;
    for (int h = 0; h < 3; h++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 4'h0 || sel !== SEL_W'(m_sel))
        $display("FAIL zero_hold h=%0d got rdy=%b valid=%b sel=%0d exp 0/0000/%0d", h, in_ready, out_valid, sel, m_sel);
      else n_pass++;
      step();
    end
    en_mask = 4'hF; out_ready = 4'hF;
    deliveries = 0;
    for (int h = 0; h < 4; h++) begin
      #1;
      if (out_valid != 0 && out_data[sel*WIDTH +: WIDTH] == 16'h5555) deliveries++;
      step();
    end
    n_checks++;
    if (deliveries != 1) $display("FAIL zero_deliver got=%0d exp=1", deliveries); else n_pass++;
    $display("mask0: deliveries=%0d", deliveries);
  endtask

  task automatic test_async_reset();
    en_mask = 4'hF; out_ready = 4'h0; in_valid = 1; in_data = 16'h0BAD;
    step();
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 4'h0 || sel !== 2'd0 || in_ready !== 1'b1 || out_data !== '0)
      $display("FAIL async_rst got valid=%b sel=%0d rdy=%b data=%h exp 0000/0/1/0", out_valid, sel, in_ready, out_data);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 4'hF;
    for (int h = 0; h < 3; h++) begin
      #1;
      n_checks++;
      if (out_valid !== 4'h0) $display("FAIL async_gone h=%0d got=%b exp=0000", h, out_valid); else n_pass++;
      step();
    end
    $display("async reset: sel=%0d out_valid=%b", sel, out_valid);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 7) == 0) en_mask = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) out_ready = 4'h0;
      in_valid  = $urandom_range(0, 1);
      in_data   = 16'($urandom);
      #1;
      n_checks++;
      if (in_ready !== exp_in_ready()) $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_in_ready());
      else n_pass++;
      n_checks++;
      if (out_valid !== exp_valid()) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid());
      else n_pass++;
      n_checks++;
      if (out_data !== exp_data()) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, exp_data());
      else n_pass++;
      n_checks++;
      if (sel !== SEL_W'(m_sel)) $display("FAIL rnd_sel c=%0d got=%0d exp=%0d", c, sel, m_sel);
      else n_pass++;
      n_checks++;
      if (skip !== m_skip) $display("FAIL rnd_skip c=%0d got=%b exp=%b", c, skip, m_skip);
      else n_pass++;
      $display("rnd %0d: mask=%b ordy=%b iv=%b sel=%0d ov=%b skip=%b", c, en_mask, out_ready, in_valid, sel, out_valid, skip);
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_mask_alternate();
    test_timeout();
    test_drop_enable();
    test_mask_zero();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
